// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: accumulator/register/stack requests in,
// register and stack state out.
interface param_reg_file_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 2,
    parameter int SP_W     = 16
);
    logic                       str_rez;
    logic [NUM_REGS-1:0]        load;
    logic [NUM_REGS-1:0]        acc_op;
    logic [DATA_W-1:0]          alu_out;
    logic [DATA_W-1:0]          dm_out;
    logic                       push;
    logic                       pop;
    logic                       err_clr;
    logic [DATA_W-1:0]          acc_out;
    logic [NUM_REGS*DATA_W-1:0] reg_out;
    logic [SP_W-1:0]            sp_out;
    logic                       stack_empty;
    logic                       stack_full;
    logic                       stack_ovf;
    logic                       stack_unf;

    modport master (
        output str_rez, load, acc_op, alu_out, dm_out, push, pop, err_clr,
        input  acc_out, reg_out, sp_out, stack_empty, stack_full, stack_ovf, stack_unf
    );

    modport slave (
        input  str_rez, load, acc_op, alu_out, dm_out, push, pop, err_clr,
        output acc_out, reg_out, sp_out, stack_empty, stack_full, stack_ovf, stack_unf
    );
endinterface

// File: rtl/param_reg_file.sv
// Accumulator, general registers and a downward-growing stack pointer.
// Define PARAM_REG_FILE_STACK_GUARD_EN for bounds-checked push/pop with sticky error flags.
module param_reg_file #(
    parameter int              DATA_W      = 16,
    parameter int              NUM_REGS    = 2,
    parameter int              SP_W        = 16,
    parameter logic [SP_W-1:0] SP_TOP      = 16'hFFFF,
    parameter int              STACK_DEPTH = 256
) (
    input logic             clk,
    input logic             reset,
    param_reg_file_if.slave bus
);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SP_W-1:0] SP_FULL = SP_TOP - SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } stack_state_t;

    logic [DATA_W-1:0] acc_p0;
    logic [DATA_W-1:0] regs_p0 [NUM_REGS];
    logic [SP_W-1:0]   sp_p0;
    stack_state_t      state_p0;
    logic              ovf_p0;
    logic              unf_p0;

    logic              push_only;
    logic              pop_only;
    logic              push_ok;
    logic              pop_ok;
    logic [SP_W-1:0]   sp_dec;
    logic [SP_W-1:0]   sp_inc;

    function automatic stack_state_t classify(input logic [SP_W-1:0] sp);
        if (sp == SP_TOP)  return ST_EMPTY;
        if (sp == SP_FULL) return ST_FULL;
        return ST_PARTIAL;
    endfunction

    // Data stage: register transfers read acc_p0 before this edge's accumulator load.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0 <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_p0[i] <= '0;
        end else begin
            if (bus.str_rez) acc_p0 <= bus.alu_out;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.load[i]) regs_p0[i] <= bus.acc_op[i] ? acc_p0 : bus.dm_out;
            end
        end
    end

    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;
    assign sp_dec    = sp_p0 - SP_ONE;
    assign sp_inc    = sp_p0 + SP_ONE;

`ifdef PARAM_REG_FILE_STACK_GUARD_EN
    assign push_ok = push_only && (state_p0 != ST_FULL);
    assign pop_ok  = pop_only && (state_p0 != ST_EMPTY);
`else
    assign push_ok = push_only;
    assign pop_ok  = pop_only;
`endif

    // Stack stage: state follows the SP value it is moving to, so depth 1 hops EMPTY<->FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_p0    <= SP_TOP;
            state_p0 <= ST_EMPTY;
            ovf_p0   <= 1'b0;
            unf_p0   <= 1'b0;
        end else begin
            if (push_ok) begin
                sp_p0    <= sp_dec;
                state_p0 <= classify(sp_dec);
            end else if (pop_ok) begin
                sp_p0    <= sp_inc;
                state_p0 <= classify(sp_inc);
            end
            // A fresh error wins over a same-cycle clear.
            ovf_p0 <= (ovf_p0 & ~bus.err_clr) | (push_only & (state_p0 == ST_FULL));
            unf_p0 <= (unf_p0 & ~bus.err_clr) | (pop_only & (state_p0 == ST_EMPTY));
        end
    end

    assign bus.acc_out     = acc_p0;
    assign bus.sp_out      = sp_p0;
    assign bus.stack_empty = (sp_p0 == SP_TOP);
    assign bus.stack_full  = (sp_p0 == SP_FULL);

    always_comb begin
        bus.reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) bus.reg_out[i*DATA_W +: DATA_W] = regs_p0[i];
    end

`ifdef PARAM_REG_FILE_STACK_GUARD_EN
    assign bus.stack_ovf = ovf_p0;
    assign bus.stack_unf = unf_p0;
`else
    logic unused_guard;
    assign unused_guard  = ^{state_p0, ovf_p0, unf_p0};
    assign bus.stack_ovf = 1'b0;
    assign bus.stack_unf = 1'b0;
`endif
endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: directed scenarios plus randomized traffic against a
// depth-counting reference model; expectations follow PARAM_REG_FILE_STACK_GUARD_EN.
`timescale 1ns/1ps
module tb_param_reg_file;
    localparam int          DATA_W   = 16;
    localparam int          NUM_REGS = 2;
    localparam int          SP_W     = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] TOP      = 16'hFFFF;
`ifdef PARAM_REG_FILE_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: stack tracked as an entry count, SP derived from it.
    logic [15:0] m_acc;
    logic [15:0] m_regs [NUM_REGS];
    int          m_depth;
    logic        m_ovf;
    logic        m_unf;

    always #5 clk = ~clk;

    param_reg_file_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SP_W(SP_W)) bus ();

    param_reg_file #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SP_W(SP_W), .SP_TOP(TOP), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [15:0] m_sp();
        return 16'(int'(TOP) - m_depth);
    endfunction

    task automatic model_tick();
        logic [15:0] old_acc;
        logic        new_ovf;
        logic        new_unf;
        if (reset) begin
            m_acc = '0;
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_depth = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            old_acc = m_acc;
            for (int i = 0; i < NUM_REGS; i++)
                if (bus.load[i]) m_regs[i] = bus.acc_op[i] ? old_acc : bus.dm_out;
            if (bus.str_rez) m_acc = bus.alu_out;
            new_ovf = 1'b0;
            new_unf = 1'b0;
            if (bus.push && !bus.pop) begin
                if (GUARD && m_depth == DEPTH) new_ovf = 1'b1;
                else m_depth++;
            end else if (bus.pop && !bus.push) begin
                if (GUARD && m_depth == 0) new_unf = 1'b1;
                else m_depth--;
            end
            m_ovf = GUARD & ((m_ovf & ~bus.err_clr) | new_ovf);
            m_unf = GUARD & ((m_unf & ~bus.err_clr) | new_unf);
        end
    endtask

    task automatic idle();
        bus.str_rez = 1'b0; bus.load = '0; bus.acc_op = '0; bus.alu_out = '0;
        bus.dm_out = '0; bus.push = 1'b0; bus.pop = 1'b0; bus.err_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        step(); step();
        n_cmp++; if (bus.acc_out !== 16'h0) begin n_err++; $display("FAIL reset_acc: got %h want 0000", bus.acc_out); end
        n_cmp++; if (bus.reg_out !== 32'h0) begin n_err++; $display("FAIL reset_regs: got %h want 00000000", bus.reg_out); end
        n_cmp++; if (bus.sp_out !== 16'hFFFF) begin n_err++; $display("FAIL reset_sp: got %h want ffff", bus.sp_out); end
        n_cmp++; if (bus.stack_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.stack_empty); end
        n_cmp++; if (bus.stack_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.stack_full); end
        n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {bus.stack_ovf, bus.stack_unf}); end
        reset = 1'b0;
    endtask

    task automatic test_acc_transfer();
        idle(); bus.str_rez = 1'b1; bus.alu_out = 16'h1234;
        step();
        n_cmp++; if (bus.acc_out !== 16'h1234) begin n_err++; $display("FAIL acc_load: got %h want 1234", bus.acc_out); end
        idle(); bus.load = 2'b01; bus.acc_op = 2'b01; bus.dm_out = 16'hDEAD;
        step();
        n_cmp++; if (bus.reg_out[15:0] !== 16'h1234) begin n_err++; $display("FAIL x_from_acc: got %h want 1234", bus.reg_out[15:0]); end
        n_cmp++; if (bus.reg_out[31:16] !== 16'h0) begin n_err++; $display("FAIL y_hold: got %h want 0000", bus.reg_out[31:16]); end
        idle(); bus.load = 2'b10; bus.acc_op = 2'b00; bus.dm_out = 16'hA5C3;
        step();
        n_cmp++; if (bus.reg_out !== 32'hA5C3_1234) begin n_err++; $display("FAIL y_from_dm: got %h want a5c31234", bus.reg_out); end
    endtask

    task automatic test_same_cycle();
        idle(); bus.str_rez = 1'b1; bus.alu_out = 16'h0005;
        step();
        idle(); bus.str_rez = 1'b1; bus.alu_out = 16'h0009; bus.load = 2'b10; bus.acc_op = 2'b10;
        step();
        n_cmp++; if (bus.reg_out[31:16] !== 16'h0005) begin n_err++; $display("FAIL same_cycle_y: got %h want 0005", bus.reg_out[31:16]); end
        n_cmp++; if (bus.acc_out !== 16'h0009) begin n_err++; $display("FAIL same_cycle_acc: got %h want 0009", bus.acc_out); end
        idle();
    endtask

    task automatic test_stack_full();
        idle(); reset = 1'b1; step(); reset = 1'b0;
        bus.push = 1'b1;
        repeat (DEPTH) step();
        n_cmp++; if (bus.sp_out !== 16'hFFFB) begin n_err++; $display("FAIL full_sp: got %h want fffb", bus.sp_out); end
        n_cmp++; if ({bus.stack_full, bus.stack_empty} !== 2'b10) begin n_err++; $display("FAIL full_decode: got %b want 10", {bus.stack_full, bus.stack_empty}); end
        step();
        n_cmp++; if (bus.sp_out !== (GUARD ? 16'hFFFB : 16'hFFFA)) begin n_err++; $display("FAIL ovf_sp: got %h want %h", bus.sp_out, GUARD ? 16'hFFFB : 16'hFFFA); end
        n_cmp++; if (bus.stack_ovf !== GUARD) begin n_err++; $display("FAIL ovf_flag: got %b want %b", bus.stack_ovf, GUARD); end
        n_cmp++; if (bus.stack_full !== GUARD) begin n_err++; $display("FAIL ovf_full: got %b want %b", bus.stack_full, GUARD); end
        bus.push = 1'b0; bus.err_clr = 1'b1;
        step();
        n_cmp++; if (bus.stack_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", bus.stack_ovf); end
        bus.push = 1'b1;
        step();
        n_cmp++; if (bus.stack_ovf !== GUARD) begin n_err++; $display("FAIL ovf_clr_race: got %b want %b", bus.stack_ovf, GUARD); end
        n_cmp++; if (bus.sp_out !== (GUARD ? 16'hFFFB : 16'hFFF9)) begin n_err++; $display("FAIL race_sp: got %h want %h", bus.sp_out, GUARD ? 16'hFFFB : 16'hFFF9); end
        idle();
    endtask

    task automatic test_underflow();
        idle(); reset = 1'b1; step(); reset = 1'b0;
        bus.pop = 1'b1;
        step();
        n_cmp++; if (bus.sp_out !== (GUARD ? 16'hFFFF : 16'h0000)) begin n_err++; $display("FAIL unf_sp: got %h want %h", bus.sp_out, GUARD ? 16'hFFFF : 16'h0000); end
        n_cmp++; if (bus.stack_unf !== GUARD) begin n_err++; $display("FAIL unf_flag: got %b want %b", bus.stack_unf, GUARD); end
        n_cmp++; if (bus.stack_empty !== GUARD) begin n_err++; $display("FAIL unf_empty: got %b want %b", bus.stack_empty, GUARD); end
        bus.pop = 1'b0; bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0; bus.push = 1'b1; bus.pop = 1'b1;
        step();
        n_cmp++; if (bus.sp_out !== (GUARD ? 16'hFFFF : 16'h0000)) begin n_err++; $display("FAIL pushpop_sp: got %h want %h", bus.sp_out, GUARD ? 16'hFFFF : 16'h0000); end
        n_cmp++; if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) begin n_err++; $display("FAIL pushpop_flags: got %b want 00", {bus.stack_ovf, bus.stack_unf}); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle(); reset = 1'b1; step(); reset = 1'b0;
        bus.push = 1'b1; bus.load = 2'b11; bus.dm_out = 16'h1111; bus.str_rez = 1'b1; bus.alu_out = 16'h2222;
        step(); step();
        reset = 1'b1; bus.push = 1'b1; bus.load = 2'b11; bus.acc_op = 2'b00; bus.dm_out = 16'hBEEF;
        bus.str_rez = 1'b1; bus.alu_out = 16'h7777;
        step();
        n_cmp++; if (bus.sp_out !== 16'hFFFF) begin n_err++; $display("FAIL rstmid_sp: got %h want ffff", bus.sp_out); end
        n_cmp++; if (bus.reg_out !== 32'h0) begin n_err++; $display("FAIL rstmid_regs: got %h want 00000000", bus.reg_out); end
        n_cmp++; if (bus.acc_out !== 16'h0) begin n_err++; $display("FAIL rstmid_acc: got %h want 0000", bus.acc_out); end
        reset = 1'b0; idle(); bus.push = 1'b1; bus.load = 2'b01; bus.dm_out = 16'hBEEF;
        step();
        n_cmp++; if (bus.sp_out !== 16'hFFFE) begin n_err++; $display("FAIL post_rst_sp: got %h want fffe", bus.sp_out); end
        n_cmp++; if (bus.reg_out !== 32'h0000_BEEF) begin n_err++; $display("FAIL post_rst_regs: got %h want 0000beef", bus.reg_out); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] exp_regs;
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 39) == 0);
            bus.str_rez = 1'($urandom);
            bus.load    = 2'($urandom);
            bus.acc_op  = 2'($urandom);
            bus.alu_out = 16'($urandom);
            bus.dm_out  = 16'($urandom);
            bus.push    = ($urandom_range(0, 9) < 5);
            bus.pop     = ($urandom_range(0, 9) < 4);
            bus.err_clr = ($urandom_range(0, 7) == 0);
            step();
            exp_regs = {m_regs[1], m_regs[0]};
            n_cmp++; if (bus.acc_out !== m_acc) begin n_err++; $display("FAIL rnd_acc c=%0d: got %h want %h", c, bus.acc_out, m_acc); end
            n_cmp++; if (bus.reg_out !== exp_regs) begin n_err++; $display("FAIL rnd_regs c=%0d: got %h want %h", c, bus.reg_out, exp_regs); end
            n_cmp++; if (bus.sp_out !== m_sp()) begin n_err++; $display("FAIL rnd_sp c=%0d: got %h want %h", c, bus.sp_out, m_sp()); end
            n_cmp++; if (bus.stack_empty !== (m_sp() == TOP)) begin n_err++; $display("FAIL rnd_empty c=%0d: got %b want %b", c, bus.stack_empty, m_sp() == TOP); end
            n_cmp++; if (bus.stack_full !== (m_sp() == TOP - 16'(DEPTH))) begin n_err++; $display("FAIL rnd_full c=%0d: got %b want %b", c, bus.stack_full, m_sp() == TOP - 16'(DEPTH)); end
            n_cmp++; if (bus.stack_ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, bus.stack_ovf, m_ovf); end
            n_cmp++; if (bus.stack_unf !== m_unf) begin n_err++; $display("FAIL rnd_unf c=%0d: got %b want %b", c, bus.stack_unf, m_unf); end
        end
        reset = 1'b0; idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_acc_transfer();
        test_same_cycle();
        test_stack_full();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter DATA_W, default 16: width of the accumulator, the general registers and the data inputs.
REQ-002 Parameter NUM_REGS, default 2: number of general registers, legal range 1..8; index 0 is X and index 1 is Y.
REQ-003 Parameter SP_W, default 16: stack pointer width.
REQ-004 Parameter SP_TOP, default 16'hFFFF: SP reset value; the stack is empty at this value.
REQ-005 Parameter STACK_DEPTH, default 256: maximum number of stacked entries, in the range 1..SP_TOP.
REQ-006 Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- str_rez  in  1  load the accumulator from alu_out.
- load  in  NUM_REGS  per-register load enable.
- acc_op  in  NUM_REGS  per-register source select: 1 = accumulator, 0 = dm_out.
- alu_out  in  DATA_W  ALU result.
- dm_out  in  DATA_W  data-memory read data.
- push  in  1  stack push request.
- pop  in  1  stack pop request.
- err_clr  in  1  clear the sticky stack error flags.
- acc_out  out  DATA_W  accumulator value.
- reg_out  out  NUM_REGS*DATA_W  all general registers; register i occupies bits [i*DATA_W +: DATA_W].
- sp_out  out  SP_W  stack pointer.
- stack_empty  out  1  SP equals SP_TOP.
- stack_full  out  1  SP equals SP_TOP-STACK_DEPTH.
- stack_ovf  out  1  sticky flag: push attempted while full.
- stack_unf  out  1  sticky flag: pop attempted while empty.
REQ-007 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-008 On a clk edge with str_rez=1, the accumulator SHALL load alu_out; with str_rez=0 it SHALL hold.
REQ-009 On a clk edge with load[i]=1, register i SHALL load the accumulator value if acc_op[i]=1, otherwise dm_out; with load[i]=0 it SHALL hold.
REQ-010 When str_rez and load[i] with acc_op[i]=1 occur in the same cycle, register i SHALL receive the pre-edge accumulator value.
REQ-011 All outputs SHALL be registered or decoded from registers only; there SHALL be no combinational path from any input to any output.
REQ-012 The stack SHALL grow downward:
- push alone: SP <= SP-1.
- pop alone: SP <= SP+1.
- Update latency is 1 cycle.
REQ-013 push and pop asserted together SHALL leave SP unchanged and SHALL set no error flag.
REQ-014 stack_empty and stack_full SHALL be combinational decodes of the current SP.
REQ-015 The stack SHALL be modelled as a state machine with states EMPTY, PARTIAL and FULL, derived from SP, with transitions:
- EMPTY to PARTIAL on push.
- PARTIAL to FULL on the push that reaches the limit.
- PARTIAL to EMPTY on the pop that reaches SP_TOP.
- FULL to PARTIAL on pop.
REQ-016 When STACK_DEPTH=1, the stack SHALL move directly between EMPTY and FULL.
REQ-017 All register, accumulator and SP arithmetic SHALL be unsigned, with modulo-width truncation.

Reset
REQ-018 On reset=1 at a clk edge, the following SHALL be cleared or set, overriding every other input in that cycle:
- acc_out = 0.
- Every register in reg_out = 0.
- sp_out = SP_TOP.
- stack_ovf = 0 and stack_unf = 0.
REQ-019 A reset asserted concurrently with push, pop, load or str_rez SHALL discard those requests.
REQ-020 The first cycle after reset deassertion SHALL accept requests normally.

Configuration
REQ-021 The macro PARAM_REG_FILE_STACK_GUARD_EN SHALL select the stack-guard feature.
REQ-022 With PARAM_REG_FILE_STACK_GUARD_EN defined, bounds protection SHALL apply:
- A push while FULL leaves SP unchanged and sets stack_ovf.
- A pop while EMPTY leaves SP unchanged and sets stack_unf.
- Both flags stay set until err_clr=1 or reset.
- When err_clr and a new error occur in the same cycle, the flag SHALL read 1 after the edge.
REQ-023 With PARAM_REG_FILE_STACK_GUARD_EN undefined, the stack SHALL be unguarded:
- SP wraps modulo 2^SP_W.
- stack_ovf and stack_unf are tied to 0.
- err_clr is ignored.
- stack_empty and stack_full still decode as specified in REQ-014.

Verification
REQ-024 Accumulator load and register transfer: with defaults, reset, then str_rez=1 with alu_out=16'h1234, then load=2'b01 with acc_op=2'b01 -> acc_out=16'h1234 and X=16'h1234 one cycle later, Y=0.
REQ-025 Same-cycle accumulator and register update: acc_out=16'h0005; in one cycle str_rez=1 with alu_out=16'h0009 and load=2'b10 with acc_op=2'b10 -> Y=16'h0005 and acc_out=16'h0009.
REQ-026 Full-to-overflow sequence (guard enabled, STACK_DEPTH=4): 4 pushes -> sp_out=16'hFFFB and stack_full=1; a 5th push -> sp_out=16'hFFFB and stack_ovf=1; err_clr -> stack_ovf=0.
REQ-027 Empty underflow, then concurrent push and pop: pop from reset -> sp_out=16'hFFFF and stack_unf=1; push=pop=1 -> sp_out unchanged and no new flag.
REQ-028 Reset mid-operation: reset asserted in the same cycle as push and load=all ones with dm_out=16'hBEEF -> sp_out=16'hFFFF and all registers 0.
REQ-029 Unguarded wrap (guard disabled, SP_TOP=16'hFFFF): a single pop -> sp_out=16'h0000 and stack_unf=0.
